seg7_scan_display: RTL
======================

Name: seg7_scan_display

Overview:
- Downstream output stage of the CPU. Takes 16-bit result words from the core (register or memory value at halt, or a debug value) and drives the board's multiplexed 4-digit 7-segment display on SEG/SEG_SEL.
- Scans one digit at a time and inserts an anti-ghost blanking gap on every digit change.
- Swaps the displayed value only at frame boundaries, so a digit never tears.
- Shows halt status on the decimal point of digit 0.

Parameters:
- SCAN_DIV, 4096: CLK cycles each digit is selected (dwell). Must be greater than BLANK_CYC.
- BLANK_CYC, 2: cycles at the start of each dwell with all selects inactive.
- BLINK_DIV, 64: frames per half-period of the halt blink.
- LZB, 1: leading-zero blanking enable.

Ports:
- CLK  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- value_valid  in  1  new display word offered
- value  in  16  display word; nibble k is shown on digit k
- value_ready  out  1  block can accept a word
- halt  in  1  CPU halted (do_halt level)
- blank  in  1  force the display dark
- SEG  out  8  segments, active-low; bit0=a .. bit6=g, bit7=dp
- SEG_SEL  out  4  digit selects, active-low; SEG_SEL[0]=rightmost digit (least significant nibble)
- frame_done  out  1  one-cycle pulse at the end of digit 3's dwell

Behaviour:
- Reset, asynchronous, while rst=0:
  - SEG=8'hFF, SEG_SEL=4'hF, value_ready=1, frame_done=0.
  - Display register=0, pending empty, digit index=0, dwell counter=0, blink phase=0, FSM=BLANK.
  - Reset asserted mid-frame or mid-handshake discards the pending word.
- Handshake:
  - A word transfers on a rising CLK edge where value_valid&&value_ready.
  - The accepted word goes to the pending register. pending_full=1 and value_ready=0 from the next cycle.
  - value is ignored while value_ready=0. The source must hold value_valid until the transfer.
- Frame boundary = the last cycle of digit 3's dwell. frame_done=1 in that cycle.
  - If pending_full: display register<=pending, pending_full<=0, value_ready=1 next cycle.
  - A word accepted in the boundary cycle itself stays pending until the following boundary.
- Scan FSM, states BLANK and DRIVE:
  - Dwell counter runs 0..SCAN_DIV-1 and wraps.
  - BLANK covers counts 0..BLANK_CYC-1: SEG_SEL=4'hF, SEG=8'hFF.
  - DRIVE covers the remaining counts: SEG_SEL[k]=0 for the current digit k, SEG=pattern.
  - At count SCAN_DIV-1 the digit index advances k->k+1 mod 4 and the FSM returns to BLANK.
  - Frame length = 4*SCAN_DIV cycles.
- Hex patterns (active-low, dp bit set):
  - 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8
  - 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E
- Leading-zero blanking (LZB=1):
  - Digit k>0 stays deselected for its whole dwell if nibbles k..3 are all zero.
  - Digit 0 is always driven, so value 0 shows "0".
- Halt:
  - The blink phase toggles every BLINK_DIV frame boundaries while halt=1. It resets to 0 when halt=0.
  - On digit 0 during DRIVE, SEG[7]=0 when halt=1 and blink phase=0. Otherwise SEG[7]=1.
- Blank:
  - blank=1 forces SEG_SEL=4'hF and SEG=8'hFF.
  - Counters, frame_done, the handshake and the blink phase keep running.
- SEG and SEG_SEL are registered: pins reflect the FSM state with one cycle of latency. frame_done is also registered and aligned to the same boundary.
- Dwell and blink counters wrap with no overflow state. Widths are sized as clog2 of the respective parameter.

Test Plan:
All scenarios use SCAN_DIV=8, BLANK_CYC=2, BLINK_DIV=2, LZB=1.
- Reset: pulse rst=0 mid-DRIVE with a word pending -> SEG=8'hFF, SEG_SEL=4'hF immediately (asynchronous), value_ready=1. After release, digit 0 shows "0" (8'hC0) and the pending word is never shown.
- Display a word: offer 16'h00A5 -> accepted in 1 cycle, value_ready=0 until the next frame_done. Next frame: SEG_SEL=4'hE with SEG=8'h92 for 6 cycles after 2 blank cycles, then SEG_SEL=4'hD with SEG=8'h88. SEG_SEL[3:2] is never 0.
- Backpressure: offer 16'h1234, then hold 16'hBEEF valid -> BEEF transfers exactly 1 cycle after the first frame boundary. 1234 shows for exactly one frame (digits 4,3,2,1 = 99,B0,A4,F9), then BEEF shows (8E,86,86,83).
- Boundary collision: the first offer's transfer lands on the frame_done cycle -> that word is displayed only after the following frame_done.
- Halt blink: halt=1 with value 16'h0007 -> digit 0 SEG=8'h78 for frames 1-2, 8'hF8 for frames 3-4, repeating. halt=0 -> 8'hF8 steadily.
- Blank: blank=1 for 3 frames -> SEG_SEL=4'hF throughout, frame_done pulses every 32 cycles, and a word offered during blank is displayed once blank=0.

Source files
------------

// File: rtl/seg7_scan_display.sv
// Drives a multiplexed 4-digit 7-segment display, one digit at a time, with a blanking gap on every digit change.
// Latency: pins lag the scan counter by one cycle; an accepted word is shown from the frame after the next frame boundary.
// Backpressure: holds one pending word; value_ready stays low until a frame boundary moves that word to the display.
module seg7_scan_display #(
  parameter int SCAN_DIV  = 4096,
  parameter int BLANK_CYC = 2,
  parameter int BLINK_DIV = 64,
  parameter int LZB       = 1
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        value_valid,
  input  logic [15:0] value,
  output logic        value_ready,
  input  logic        halt,
  input  logic        blank,
  output logic [7:0]  SEG,
  output logic [3:0]  SEG_SEL,
  output logic        frame_done
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_CYC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          cnt_wrap;
  logic [1:0]    dig;
  logic [15:0]   disp;
  logic [15:0]   disp_nxt;
  logic [15:0]   pend;
  logic          pend_full;
  logic [BW-1:0] blink_cnt;
  logic          blink_ph;
  logic [3:0]    nib;
  logic          lz_off;
  logic [7:0]    pat;
  logic          drive;
  logic          dp_n;

  assign value_ready = !pend_full;
  assign cnt_wrap    = (cnt == CNT_LAST);
  assign cnt_nxt     = cnt_wrap ? '0 : cnt + CW'(1);

  // Use the post-swap word so the first cycle of a new frame already sees it.
  always_comb begin
    disp_nxt = disp;
    if (frame_done && pend_full)
      disp_nxt = pend;
  end

  always_comb begin
    nib    = disp_nxt[3:0];
    lz_off = 1'b0;
    case (dig)
      2'd0: nib = disp_nxt[3:0];
      2'd1: begin
        nib    = disp_nxt[7:4];
        lz_off = (disp_nxt[15:4] == 12'h000);
      end
      2'd2: begin
        nib    = disp_nxt[11:8];
        lz_off = (disp_nxt[15:8] == 8'h00);
      end
      2'd3: begin
        nib    = disp_nxt[15:12];
        lz_off = (disp_nxt[15:12] == 4'h0);
      end
      default: nib = disp_nxt[3:0];
    endcase
    if (LZB == 0)
      lz_off = 1'b0;
  end

  always_comb begin
    pat = 8'hFF;
    case (nib)
      4'h0: pat = 8'hC0;
      4'h1: pat = 8'hF9;
      4'h2: pat = 8'hA4;
      4'h3: pat = 8'hB0;
      4'h4: pat = 8'h99;
      4'h5: pat = 8'h92;
      4'h6: pat = 8'h82;
      4'h7: pat = 8'hF8;
      4'h8: pat = 8'h80;
      4'h9: pat = 8'h90;
      4'hA: pat = 8'h88;
      4'hB: pat = 8'h83;
      4'hC: pat = 8'hC6;
      4'hD: pat = 8'hA1;
      4'hE: pat = 8'h86;
      4'hF: pat = 8'h8E;
      default: pat = 8'hFF;
    endcase
  end

  assign drive = (state == ST_DRIVE) && !blank && !lz_off;
  assign dp_n  = !((dig == 2'd0) && halt && !blink_ph);

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      SEG        <= 8'hFF;
      SEG_SEL    <= 4'hF;
      frame_done <= 1'b0;
      state      <= ST_BLANK;
      cnt        <= '0;
      dig        <= 2'd0;
      disp       <= '0;
      pend       <= '0;
      pend_full  <= 1'b0;
      blink_cnt  <= '0;
      blink_ph   <= 1'b0;
    end else begin
      frame_done <= cnt_wrap && (dig == 2'd3);
      SEG_SEL    <= drive ? ~(4'b0001 << dig) : 4'hF;
      SEG        <= drive ? {dp_n, pat[6:0]} : 8'hFF;

      cnt   <= cnt_nxt;
      state <= (cnt_nxt < BLANK_END) ? ST_BLANK : ST_DRIVE;
      if (cnt_wrap)
        dig <= dig + 2'd1;

      disp <= disp_nxt;
      // Accept and swap are exclusive: a full pending slot blocks acceptance.
      if (value_valid && !pend_full) begin
        pend      <= value;
        pend_full <= 1'b1;
      end else if (frame_done) begin
        pend_full <= 1'b0;
      end

      if (!halt) begin
        blink_cnt <= '0;
        blink_ph  <= 1'b0;
      end else if (frame_done) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink_ph  <= !blink_ph;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end
endmodule
